// File: rtl/load_hazard_sb.sv
// ============================================================================
// Module   : load_hazard_sb
// Brief    : Outstanding-load scoreboard producing a combinational ID stall.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module load_hazard_sb #(
    parameter int NUM_PEND = 4,
    parameter int LOAD_LAT = 1,
    parameter int CNT_W    = 16
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic [6:0]       OPCODE,
    input  logic [4:0]       ADDR1,
    input  logic [4:0]       ADDR2,
    input  logic [4:0]       RD_ADDR,
    input  logic [3:0]       READ_WRITE,
    input  logic             ISSUE_VALID,
    input  logic             MEM_WAIT,
    output logic             STALL,
    output logic             SB_FULL,
    output logic [CNT_W-1:0] STALL_CNT
);

    localparam int CD_W = $clog2(LOAD_LAT + 1);

    localparam logic [6:0] c_OP_JALR   = 7'b1100111;
    localparam logic [6:0] c_OP_BRANCH = 7'b1100011;
    localparam logic [6:0] c_OP_IMM    = 7'b0010011;
    localparam logic [6:0] c_OP_OP     = 7'b0110011;
    localparam logic [6:0] c_OP_LOAD   = 7'b0000011;
    localparam logic [6:0] c_OP_STORE  = 7'b0100011;

    logic [NUM_PEND-1:0] r_valid;
    logic [4:0]          r_rd  [NUM_PEND];
    logic [CD_W-1:0]     r_cnt [NUM_PEND];
    logic [CNT_W-1:0]    r_stall_cnt;

    logic                w_rs1_use;
    logic                w_rs2_use;
    logic                w_is_load;
    logic                w_data_haz;
    logic                w_struct_haz;
    logic                w_alloc;
    logic                w_found;
    logic [NUM_PEND-1:0] w_alloc_oh;

    assign w_rs1_use = (OPCODE == c_OP_JALR)  || (OPCODE == c_OP_BRANCH) ||
                       (OPCODE == c_OP_IMM)   || (OPCODE == c_OP_OP)     ||
                       (OPCODE == c_OP_LOAD)  || (OPCODE == c_OP_STORE);
    assign w_rs2_use = (OPCODE == c_OP_BRANCH) || (OPCODE == c_OP_OP) ||
                       (OPCODE == c_OP_STORE);

    // Load-ness comes from the memory op code: LB, LH, LW, LBU, LHU.
    assign w_is_load = (READ_WRITE == 4'b1000) || (READ_WRITE == 4'b1001) ||
                       (READ_WRITE == 4'b1010) || (READ_WRITE == 4'b1100) ||
                       (READ_WRITE == 4'b1101);

    always_comb begin
        w_data_haz = 1'b0;
        for (int i = 0; i < NUM_PEND; i++) begin
            if (r_valid[i] &&
                ((w_rs1_use && (ADDR1 != 5'd0) && (r_rd[i] == ADDR1)) ||
                 (w_rs2_use && (ADDR2 != 5'd0) && (r_rd[i] == ADDR2))))
                w_data_haz = 1'b1;
        end
    end

    // Uses registered fullness only, so a same-edge free cannot unblock a load.
    assign w_struct_haz = w_is_load && (RD_ADDR != 5'd0) && SB_FULL;

    assign SB_FULL   = &r_valid;
    assign STALL     = RST_N && ISSUE_VALID && (w_data_haz || w_struct_haz);
    assign STALL_CNT = r_stall_cnt;
    assign w_alloc   = RST_N && ISSUE_VALID && !STALL && w_is_load && (RD_ADDR != 5'd0);

    always_comb begin
        w_alloc_oh = '0;
        w_found    = 1'b0;
        for (int i = 0; i < NUM_PEND; i++) begin
            if (!r_valid[i] && !w_found) begin
                w_alloc_oh[i] = 1'b1;
                w_found       = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_valid     <= '0;
            r_stall_cnt <= '0;
            for (int i = 0; i < NUM_PEND; i++) begin
                r_rd[i]  <= '0;
                r_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_PEND; i++) begin
                if (w_alloc && w_alloc_oh[i]) begin
                    r_valid[i] <= 1'b1;
                    r_rd[i]    <= RD_ADDR;
                    r_cnt[i]   <= CD_W'(LOAD_LAT);
                end else if (r_valid[i] && !MEM_WAIT) begin
                    r_cnt[i] <= r_cnt[i] - CD_W'(1);
                    if (r_cnt[i] == CD_W'(1))
                        r_valid[i] <= 1'b0;
                end
            end
            if (STALL && (r_stall_cnt != {CNT_W{1'b1}}))
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_load_hazard_sb.sv
// ============================================================================
// Module   : tb_load_hazard_sb
// Brief    : Directed bench for load_hazard_sb across three parameter sets.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_load_hazard_sb;

    localparam logic [6:0] c_LOAD   = 7'b0000011;
    localparam logic [6:0] c_OP     = 7'b0110011;
    localparam logic [6:0] c_IMM    = 7'b0010011;
    localparam logic [6:0] c_BRANCH = 7'b1100011;

    logic        CLK;
    logic        RST_N;
    logic [6:0]  OPCODE;
    logic [4:0]  ADDR1;
    logic [4:0]  ADDR2;
    logic [4:0]  RD_ADDR;
    logic [3:0]  READ_WRITE;
    logic        ISSUE_VALID;
    logic        MEM_WAIT;

    logic        a_stall, a_full;
    logic [15:0] a_cnt;
    logic        b_stall, b_full;
    logic [15:0] b_cnt;
    logic        c_stall, c_full;
    logic [2:0]  c_cnt;

    int n_vec = 0;
    int n_mis = 0;

    // a: defaults, b: 3-cycle latency, c: 2 entries / 4-cycle latency / 3-bit counter
    load_hazard_sb u_a (
        .CLK(CLK), .RST_N(RST_N), .OPCODE(OPCODE), .ADDR1(ADDR1), .ADDR2(ADDR2),
        .RD_ADDR(RD_ADDR), .READ_WRITE(READ_WRITE), .ISSUE_VALID(ISSUE_VALID),
        .MEM_WAIT(MEM_WAIT), .STALL(a_stall), .SB_FULL(a_full), .STALL_CNT(a_cnt)
    );

    load_hazard_sb #(.NUM_PEND(4), .LOAD_LAT(3), .CNT_W(16)) u_b (
        .CLK(CLK), .RST_N(RST_N), .OPCODE(OPCODE), .ADDR1(ADDR1), .ADDR2(ADDR2),
        .RD_ADDR(RD_ADDR), .READ_WRITE(READ_WRITE), .ISSUE_VALID(ISSUE_VALID),
        .MEM_WAIT(MEM_WAIT), .STALL(b_stall), .SB_FULL(b_full), .STALL_CNT(b_cnt)
    );

    load_hazard_sb #(.NUM_PEND(2), .LOAD_LAT(4), .CNT_W(3)) u_c (
        .CLK(CLK), .RST_N(RST_N), .OPCODE(OPCODE), .ADDR1(ADDR1), .ADDR2(ADDR2),
        .RD_ADDR(RD_ADDR), .READ_WRITE(READ_WRITE), .ISSUE_VALID(ISSUE_VALID),
        .MEM_WAIT(MEM_WAIT), .STALL(c_stall), .SB_FULL(c_full), .STALL_CNT(c_cnt)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(input logic v, input logic [6:0] op, input logic [3:0] rw,
                         input logic [4:0] a1, input logic [4:0] a2, input logic [4:0] rd);
        ISSUE_VALID = v;
        OPCODE      = op;
        READ_WRITE  = rw;
        ADDR1       = a1;
        ADDR2       = a2;
        RD_ADDR     = rd;
    endtask

    task automatic ld(input logic [4:0] rd, input logic [3:0] rw);
        drive(1'b1, c_LOAD, rw, 5'd0, 5'd0, rd);
    endtask

    task automatic reset_all();
        drive(1'b0, 7'd0, 4'd0, 5'd0, 5'd0, 5'd0);
        MEM_WAIT = 1'b0;
        RST_N    = 1'b0;
        tick();
        RST_N    = 1'b1;
    endtask

    initial begin
        RST_N    = 1'b0;
        MEM_WAIT = 1'b0;
        drive(1'b0, 7'd0, 4'd0, 5'd0, 5'd0, 5'd0);
        #2;
        tick();
        tick();
        chk("rst_stall", {15'd0, a_stall}, 16'd0);
        chk("rst_full",  {15'd0, a_full},  16'd0);
        chk("rst_cnt_a", a_cnt, 16'd0);
        chk("rst_cnt_c", {13'd0, c_cnt}, 16'd0);
        RST_N = 1'b1;

        // load-use bubble, LOAD_LAT=1
        ld(5'd5, 4'b1010); #1;
        chk("lu_ld_nostall", {15'd0, a_stall}, 16'd0);
        tick();
        drive(1'b1, c_IMM, 4'b0000, 5'd2, 5'd5, 5'd10); #1;
        chk("lu_addi_rs2_ignored", {15'd0, a_stall}, 16'd0);
        drive(1'b0, c_OP, 4'b0000, 5'd5, 5'd6, 5'd10); #1;
        chk("lu_invalid_nostall", {15'd0, a_stall}, 16'd0);
        drive(1'b1, c_OP, 4'b0000, 5'd5, 5'd6, 5'd10); #1;
        chk("lu_add_stall", {15'd0, a_stall}, 16'd1);
        tick();
        chk("lu_add_release", {15'd0, a_stall}, 16'd0);
        chk("lu_cnt", a_cnt, 16'd1);
        tick();

        // LOAD_LAT=3, rs2 dependency
        reset_all();
        ld(5'd7, 4'b1010);
        tick();
        drive(1'b1, c_BRANCH, 4'b0000, 5'd1, 5'd7, 5'd0); #1;
        for (int k = 0; k < 3; k++) begin
            chk("beq_stall", {15'd0, b_stall}, 16'd1);
            tick();
        end
        chk("beq_release", {15'd0, b_stall}, 16'd0);
        chk("beq_cnt", b_cnt, 16'd3);

        // same, with two frozen cycles
        reset_all();
        ld(5'd7, 4'b1001);
        tick();
        drive(1'b1, c_BRANCH, 4'b0000, 5'd1, 5'd7, 5'd0);
        MEM_WAIT = 1'b1; #1;
        chk("mw_stall1", {15'd0, b_stall}, 16'd1);
        tick();
        chk("mw_stall2", {15'd0, b_stall}, 16'd1);
        tick();
        MEM_WAIT = 1'b0; #1;
        chk("mw_stall3", {15'd0, b_stall}, 16'd1);
        tick();
        chk("mw_stall4", {15'd0, b_stall}, 16'd1);
        tick();
        chk("mw_stall5", {15'd0, b_stall}, 16'd1);
        tick();
        chk("mw_release", {15'd0, b_stall}, 16'd0);
        chk("mw_cnt", b_cnt, 16'd5);

        // duplicate rd: hazard holds until the younger entry frees
        reset_all();
        ld(5'd8, 4'b1010);
        tick();
        ld(5'd8, 4'b1100); #1;
        chk("dup_ld2_nostall", {15'd0, b_stall}, 16'd0);
        tick();
        drive(1'b1, c_OP, 4'b0000, 5'd8, 5'd0, 5'd11); #1;
        for (int k = 0; k < 3; k++) begin
            chk("dup_stall", {15'd0, b_stall}, 16'd1);
            tick();
        end
        chk("dup_release", {15'd0, b_stall}, 16'd0);

        // reset mid-countdown
        reset_all();
        ld(5'd9, 4'b1010);
        tick();
        drive(1'b1, c_OP, 4'b0000, 5'd9, 5'd0, 5'd12); #1;
        chk("rmid_stall", {15'd0, b_stall}, 16'd1);
        RST_N = 1'b0; #1;
        chk("rmid_forced_low", {15'd0, b_stall}, 16'd0);
        tick();
        RST_N = 1'b1; #1;
        chk("rmid_post_stall", {15'd0, b_stall}, 16'd0);
        chk("rmid_post_cnt", b_cnt, 16'd0);
        chk("rmid_post_full", {15'd0, b_full}, 16'd0);
        RST_N = 1'b0;
        ld(5'd9, 4'b1010);
        tick();
        RST_N = 1'b1;
        drive(1'b1, c_OP, 4'b0000, 5'd9, 5'd0, 5'd12); #1;
        chk("rst_no_alloc", {15'd0, b_stall}, 16'd0);

        // rd=0 loads allocate nothing
        reset_all();
        ld(5'd0, 4'b1010);
        tick();
        ld(5'd0, 4'b1101);
        tick();
        drive(1'b1, c_OP, 4'b0000, 5'd0, 5'd0, 5'd13); #1;
        chk("x0_stall", {15'd0, a_stall}, 16'd0);
        chk("x0_full_a", {15'd0, a_full}, 16'd0);
        chk("x0_full_c", {15'd0, c_full}, 16'd0);

        // structural hazard, NUM_PEND=2 LOAD_LAT=4
        reset_all();
        ld(5'd1, 4'b1010);
        tick();
        ld(5'd2, 4'b1010);
        tick();
        chk("st_full", {15'd0, c_full}, 16'd1);
        ld(5'd3, 4'b1010); #1;
        chk("st_stall1", {15'd0, c_stall}, 16'd1);
        tick();
        chk("st_stall2", {15'd0, c_stall}, 16'd1);
        tick();
        chk("st_stall_free_edge", {15'd0, c_stall}, 16'd1);
        tick();
        chk("st_release", {15'd0, c_stall}, 16'd0);
        chk("st_release_full", {15'd0, c_full}, 16'd0);
        tick();
        chk("st_cnt", {13'd0, c_cnt}, 16'd3);
        drive(1'b1, c_OP, 4'b0000, 5'd3, 5'd0, 5'd14); #1;
        chk("st_rd3_pending", {15'd0, c_stall}, 16'd1);
        drive(1'b1, c_OP, 4'b0000, 5'd2, 5'd0, 5'd14); #1;
        chk("st_rd2_freed", {15'd0, c_stall}, 16'd0);

        // saturation of a 3-bit counter
        reset_all();
        ld(5'd4, 4'b1010);
        tick();
        drive(1'b1, c_OP, 4'b0000, 5'd4, 5'd0, 5'd15);
        MEM_WAIT = 1'b1;
        repeat (6) tick();
        chk("sat_six", {13'd0, c_cnt}, 16'd6);
        tick();
        chk("sat_seven", {13'd0, c_cnt}, 16'd7);
        tick();
        tick();
        chk("sat_hold", {13'd0, c_cnt}, 16'd7);
        chk("sat_still_stall", {15'd0, c_stall}, 16'd1);

        // allocation under MEM_WAIT fills the scoreboard
        reset_all();
        MEM_WAIT = 1'b1;
        ld(5'd1, 4'b1010); tick();
        ld(5'd2, 4'b1010); tick();
        ld(5'd3, 4'b1010); #1;
        chk("fill_not_full", {15'd0, a_full}, 16'd0);
        tick();
        ld(5'd4, 4'b1010); tick();
        chk("fill_full", {15'd0, a_full}, 16'd1);
        ld(5'd5, 4'b1010); #1;
        chk("fill_struct_stall", {15'd0, a_stall}, 16'd1);
        MEM_WAIT = 1'b0;
        drive(1'b0, 7'd0, 4'd0, 5'd0, 5'd0, 5'd0);
        tick();
        chk("fill_drained", {15'd0, a_full}, 16'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule

`default_nettype wire
